// File: rtl/qsys_pio_pkg.sv
// Shared definitions for the Qsys key/switch PIO: register map and edge-type encodings.
package qsys_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // True when the stable value is about to change in the direction of interest.
    function automatic logic edge_hit(input int edge_type, input logic cur, input logic nxt);
        logic changed;
        changed = cur ^ nxt;
        case (edge_type)
            EDGE_RISING:  return changed & nxt;
            EDGE_FALLING: return changed & ~nxt;
            default:      return changed;
        endcase
    endfunction

endpackage

// File: rtl/qsys_key_debounce_bit.sv
// One input bit: 2-flop synchroniser, optional debouncer, edge event.
// Optional debouncer enabled by defining QSYS_KEY_PIO_DEBOUNCE_EN.
// edge_event is asserted in the cycle before stable changes, so the capture
// register in the parent updates on the same edge as stable.
module qsys_key_debounce_bit
    import qsys_pio_pkg::*;
#(
    parameter int EDGE_TYPE       = EDGE_FALLING,
    parameter int RESET_LEVEL     = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic stable,
    output logic edge_event
);

    localparam logic RL = RESET_LEVEL[0];

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1;
    logic sync2;
    logic stable_next;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RL;
            sync2 <= RL;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
        end
    end

`ifdef QSYS_KEY_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          stable_q;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable_q;
        if (sync2 != stable_q) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_next = sync2;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Debounced value and its counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= RL;
            cnt      <= '0;
        end else begin
            stable_q <= stable_next;
            cnt      <= cnt_next;
        end
    end

    assign stable = stable_q;
`else
    assign stable_next = sync1;
    assign stable      = sync2;
`endif

    assign edge_event = edge_hit(EDGE_TYPE, stable, stable_next);

endmodule

// File: rtl/qsys_key_pio_irq.sv
// Avalon-MM input PIO with per-bit edge capture (W1C) and a masked level IRQ.
// Optional debouncer enabled by defining QSYS_KEY_PIO_DEBOUNCE_EN.
module qsys_key_pio_irq
    import qsys_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = EDGE_FALLING,
    parameter int RESET_LEVEL     = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be in 1..32");
    end

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      read_mux;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        qsys_key_debounce_bit #(
            .EDGE_TYPE       (EDGE_TYPE),
            .RESET_LEVEL     (RESET_LEVEL),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .in_bit     (in_port[i]),
            .stable     (stable[i]),
            .edge_event (edge_event[i])
        );
    end

    assign wr_en        = chipselect & ~write_n;
    assign clear_bits   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // Mask register and sticky edge capture; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= edge_event | (edge_capture & ~clear_bits);
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA: read_mux[WIDTH-1:0] = stable;
            ADDR_MASK: read_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: read_mux[WIDTH-1:0] = edge_capture;
            default:   read_mux = '0;
        endcase
    end

    // Registered read data, refreshed every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_qsys_key_pio_irq.sv
// Directed bench: two instances share bus and inputs; dut_a captures falling
// edges, dut_b captures any edge.
module tb_qsys_key_pio_irq;

`ifdef QSYS_KEY_PIO_DEBOUNCE_EN
    localparam int DB  = 16;
    localparam int LAT = 2 + DB;
    localparam int PRE = 10;
`else
    localparam int DB  = 16;
    localparam int LAT = 2;
    localparam int PRE = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qsys_key_pio_irq #(.WIDTH(4), .EDGE_TYPE(1), .RESET_LEVEL(1), .DEBOUNCE_CYCLES(DB)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_a), .irq(irq_a)
    );

    qsys_key_pio_irq #(.WIDTH(4), .EDGE_TYPE(2), .RESET_LEVEL(1), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_b), .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a,
                            input logic [31:0] exp_a, input logic [31:0] exp_b);
        address = a;
        @(negedge clk);
        chk({tag, "_a"}, readdata_a, exp_a);
        chk({tag, "_b"}, readdata_b, exp_b);
    endtask

    task automatic irq_chk(input string tag, input logic exp_a, input logic exp_b);
        chk({tag, "_irq_a"}, {31'd0, irq_a}, {31'd0, exp_a});
        chk({tag, "_irq_b"}, {31'd0, irq_b}, {31'd0, exp_b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        wait_cycles(3);
        chk("rst_rd_a", readdata_a, 32'h0);
        chk("rst_rd_b", readdata_b, 32'h0);
        irq_chk("rst", 1'b0, 1'b0);
        reset = 1'b0;
        wait_cycles(2);

        // Idle reads after reset
        read_chk("t1_data", 2'd0, 32'hF, 32'hF);
        read_chk("t1_mask", 2'd2, 32'h0, 32'h0);
        read_chk("t1_edge", 2'd3, 32'h0, 32'h0);
        irq_chk("t1", 1'b0, 1'b0);

        // Falling edge on bit 0, then W1C
        bus_write(2'd2, 32'h1);
        read_chk("t2_mask", 2'd2, 32'h1, 32'h1);
        in_port = 4'hE;
        wait_cycles(LAT - 1);
        irq_chk("t2_early", 1'b0, 1'b0);
        wait_cycles(1);
        irq_chk("t2_set", 1'b1, 1'b1);
        read_chk("t2_edge", 2'd3, 32'h1, 32'h1);
        read_chk("t2_data", 2'd0, 32'hE, 32'hE);
        bus_write(2'd3, 32'h1);
        irq_chk("t2_clr", 1'b0, 1'b0);
        read_chk("t2_edge_clr", 2'd3, 32'h0, 32'h0);

        // Rising edge on bit 0: only the any-edge instance captures
        in_port = 4'hF;
        wait_cycles(LAT + 1);
        irq_chk("t2r", 1'b0, 1'b1);
        read_chk("t2r_edge", 2'd3, 32'h0, 32'h1);
        read_chk("t2r_data", 2'd0, 32'hF, 32'hF);
        bus_write(2'd3, 32'h1);
        irq_chk("t2r_clr", 1'b0, 1'b0);

        // Glitch on bit 2
`ifdef QSYS_KEY_PIO_DEBOUNCE_EN
        in_port = 4'hB;
        wait_cycles(10);
        in_port = 4'hF;
        wait_cycles(LAT + 2);
        read_chk("t3_short_data", 2'd0, 32'hF, 32'hF);
        read_chk("t3_short_edge", 2'd3, 32'h0, 32'h0);
        in_port = 4'hB;
        wait_cycles(20);
        read_chk("t3_long_data", 2'd0, 32'hB, 32'hB);
        read_chk("t3_long_edge", 2'd3, 32'h4, 32'h4);
        in_port = 4'hF;
        wait_cycles(LAT + 2);
        read_chk("t3_back_edge", 2'd3, 32'h4, 32'h4);
        bus_write(2'd3, 32'h4);
`else
        in_port = 4'hB;
        wait_cycles(1);
        in_port = 4'hF;
        wait_cycles(4);
        read_chk("t3_edge", 2'd3, 32'h4, 32'h4);
        read_chk("t3_data", 2'd0, 32'hF, 32'hF);
        bus_write(2'd3, 32'h4);
`endif
        read_chk("t3_edge_clr", 2'd3, 32'h0, 32'h0);
        irq_chk("t3", 1'b0, 1'b0);

        // Same-cycle W1C and new falling edge on bit 1
        bus_write(2'd2, 32'h2);
        in_port = 4'hD;
        wait_cycles(LAT);
        irq_chk("t4_first", 1'b1, 1'b1);
        in_port = 4'hF;
        wait_cycles(LAT + 1);
        read_chk("t4_absorb", 2'd3, 32'h2, 32'h2);
        in_port = 4'hD;
        wait_cycles(LAT - 1);
        bus_write(2'd3, 32'h2);
        irq_chk("t4_race", 1'b1, 1'b1);
        read_chk("t4_race_edge", 2'd3, 32'h2, 32'h2);
        bus_write(2'd3, 32'h2);
        irq_chk("t4_clr", 1'b0, 1'b0);
        read_chk("t4_edge_clr", 2'd3, 32'h0, 32'h0);
        in_port = 4'hF;
        wait_cycles(LAT + 1);
        bus_write(2'd3, 32'h2);

        // Masked capture on bit 3, then unmask
        bus_write(2'd2, 32'h0);
        in_port = 4'h7;
        wait_cycles(LAT + 1);
        irq_chk("t5_masked", 1'b0, 1'b0);
        read_chk("t5_edge_fall", 2'd3, 32'h8, 32'h8);
        in_port = 4'hF;
        wait_cycles(LAT + 1);
        read_chk("t5_edge_rise", 2'd3, 32'h8, 32'h8);
        address    = 2'd2;
        writedata  = 32'h8;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        irq_chk("t5_pre_write", 1'b0, 1'b0);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        irq_chk("t5_unmask", 1'b1, 1'b1);
        bus_write(2'd1, 32'hFFFF_FFFF);
        read_chk("t5_reserved", 2'd1, 32'h0, 32'h0);
        read_chk("t5_mask", 2'd2, 32'h8, 32'h8);
        bus_write(2'd3, 32'h8);
        irq_chk("t5_clr", 1'b0, 1'b0);

        // Reset in the middle of a pending change on bit 2
        in_port = 4'hB;
        wait_cycles(PRE);
        reset   = 1'b1;
        in_port = 4'hF;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(LAT + 2);
        irq_chk("t6_after", 1'b0, 1'b0);
        read_chk("t6_edge", 2'd3, 32'h0, 32'h0);
        read_chk("t6_data", 2'd0, 32'hF, 32'hF);
        read_chk("t6_mask", 2'd2, 32'h0, 32'h0);
        bus_write(2'd2, 32'h4);
        in_port = 4'hB;
        wait_cycles(LAT - 1);
        irq_chk("t6_fresh_early", 1'b0, 1'b0);
        wait_cycles(1);
        irq_chk("t6_fresh_set", 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
